lcd_char_feeder: RTL and testbench
==================================

// Module: lcd_char_feeder
// PURPOSE
//  Upstream stage of the LCD controller. Buffers characters from user logic in a FIFO and tracks the cursor on a COLS x ROWS display.
//  Presents DDRAM-address commands and character data one item at a time on the controller's addrOrData/dataInBus inputs.
//  Every presented item is paced by the controller's busLock signal.
// PARAMETERS
//  FIFO_DEPTH   16     character FIFO entries; power of 2, >=2
//  COLS         16     characters per display line
//  ROWS         2      display lines, 1 or 2
//  LINE0_BASE   7'h00  DDRAM address of row 0, col 0
//  LINE1_BASE   7'h40  DDRAM address of row 1, col 0
//  HOLD_CYCLES  2500   unlocked cycles each item is held (50us at 50MHz)
// PORTS
//  clk            in   1   system clock, 50MHz
//  rst            in   1   asynchronous reset, active-high
//  charValid      in   1   user character strobe
//  charData       in   8   character code; 8'h0A = newline
//  charReady      out  1   FIFO can accept; a transfer occurs on charValid & charReady
//  clearReq       in   1   single-cycle pulse: flush FIFO, home cursor
//  lcdBusLock     in   1   from controller; 1 = locked, hold count frozen
//  lcdValid       out  1   an item is being presented
//  lcdAddrOrData  out  1   0 = address command, 1 = character data
//  lcdDataOut     out  8   {1'b1, addr[6:0]} for address items; character code for data items
//  fifoCount      out  clog2(FIFO_DEPTH)+1   current FIFO occupancy
//  cursorPos      out  8   {row[3:0], col[3:0]} of next character cell
// BEHAVIOUR
//  Reset (async, while rst=1):
//   - All outputs are 0, including charReady.
//   - FIFO is empty, cursor is 0/0, addrPending=1, state is IDLE, hold counter is 0.
//   - Reset mid-hold abandons the item with no further output.
//  charReady:
//   - Registered. Equals 1 iff count<FIFO_DEPTH and no clearReq in the previous cycle.
//   - No write-through when full: push+pop in the same cycle is legal only when count<FIFO_DEPTH.
//  FSM states: IDLE, ADDR, DATA.
//   - IDLE, count>0: pop head into charLatch.
//       - Latched char is 8'h0A, or addrPending=1: go to ADDR.
//       - Otherwise: go to DATA.
//   - ADDR: present lcdValid=1, lcdAddrOrData=0, lcdDataOut={1,base(row)+col}.
//   - DATA: present lcdValid=1, lcdAddrOrData=1, lcdDataOut=charLatch.
//   - Outputs are registered and valid the cycle after the pop edge.
//  Hold rule:
//   - The counter increments only on cycles with lcdBusLock=0. Outputs are stable for the whole item.
//   - The item completes on the cycle the counter reaches HOLD_CYCLES-1.
//   - On completion, the counter clears and lcdValid drops for exactly one cycle (IDLE), unless ADDR->DATA chains.
//  ADDR completion:
//   - Clears addrPending.
//   - Latched char 8'h0A: cursor already moved; go to IDLE.
//   - Otherwise: go to DATA with the same charLatch.
//  Newline: the pop edge sets col=0, row=(row+1)%ROWS. The ADDR item then uses the new cursor.
//  DATA completion: col+1. When col reaches COLS, set col=0, row=(row+1)%ROWS and addrPending=1.
//   - Last cell of last row wraps to row 0, col 0.
//  clearReq (any state, highest priority after rst):
//   - The next edge empties the FIFO, sets cursor 0/0 and addrPending=1, returns to IDLE, drops lcdValid, and zeroes the counter.
//   - A charValid in the same cycle is dropped.
//  Latency: char accepted at edge N with FIFO empty and FSM in IDLE -> popped at edge N+1 -> lcdValid=1 after edge N+1.
//  Chars are never lost or reordered except by clearReq or rst.
// TESTING
//  1. Reset, then push 'A'(8'h41), lock=0 throughout:
//     - ADDR 8'h80 held 2500 cycles, then DATA 8'h41 held 2500 cycles.
//     - cursorPos ends at 8'h01.
//  2. Push 17 chars:
//     - 16 DATA items after the initial ADDR 8'h80, then ADDR 8'hC0, then the 17th char.
//     - cursorPos ends at 8'h11.
//  3. Fill 33 cells:
//     - After the 32nd char, wrap emits ADDR 8'h80 before the 33rd char.
//     - cursorPos ends at 8'h01.
//  4. Push 'H', 8'h0A, 'I':
//     - ADDR 8'h80, DATA 8'h48, ADDR 8'hC0, DATA 8'h49.
//     - 8'h0A never appears as data.
//  5. Hold lcdBusLock=1 for 1000 cycles mid-DATA:
//     - Item lasts 2500+1000 cycles; lcdDataOut is stable throughout.
//  6. Overflow and clear:
//     - Push 20 chars while locked: charReady=0 once fifoCount=16; 4 chars are refused.
//     - Pulse clearReq: next cycle fifoCount=0, lcdValid=0, cursorPos=0.
//     - Pulse rst mid-hold: all outputs 0 immediately.

Source files
------------

// File: rtl/lcd_char_feeder.sv
// Character FIFO plus cursor tracker that feeds DDRAM-address and character
// items to the LCD controller, holding each one for HOLD_CYCLES unlocked cycles.
module lcd_char_feeder #(
  parameter int         FIFO_DEPTH  = 16,
  parameter int         COLS        = 16,
  parameter int         ROWS        = 2,
  parameter logic [6:0] LINE0_BASE  = 7'h00,
  parameter logic [6:0] LINE1_BASE  = 7'h40,
  parameter int         HOLD_CYCLES = 2500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          charValid_i,
  input  logic [7:0]                    charData_i,
  output logic                          charReady_o,
  input  logic                          clearReq_i,
  input  logic                          lcdBusLock_i,
  output logic                          lcdValid_o,
  output logic                          lcdAddrOrData_o,
  output logic [7:0]                    lcdDataOut_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount_o,
  output logic [7:0]                    cursorPos_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [7:0] NEWLINE = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            charReady_q, charReady_d;
  logic [7:0]      charLatch_q, charLatch_d;
  logic [3:0]      row_q, row_d;
  logic [3:0]      col_q, col_d;
  logic            addrPending_q, addrPending_d;
  logic [HW-1:0]   holdCnt_q, holdCnt_d;
  logic            lcdValid_q, lcdValid_d;
  logic            lcdAod_q, lcdAod_d;
  logic [7:0]      lcdData_q, lcdData_d;

  logic            push;
  logic            pop;
  logic [7:0]      headChar;
  logic [4:0]      colPlus;

  function automatic logic [3:0] nextRow(input logic [3:0] r);
    return (r == 4'(ROWS - 1)) ? 4'd0 : r + 4'd1;
  endfunction

  function automatic logic [7:0] addrCmd(input logic [3:0] r, input logic [3:0] c);
    logic [6:0] base;
    base = (r == 4'd0) ? LINE0_BASE : LINE1_BASE;
    return {1'b1, base + {3'b000, c}};
  endfunction

  assign push     = charValid_i & charReady_q & ~clearReq_i;
  assign pop      = (state_q == IDLE) && (count_q != '0) && !clearReq_i;
  assign headChar = mem_q[rdPtr_q];
  assign colPlus  = {1'b0, col_q} + 5'd1;

  always_comb begin
    state_d       = state_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    count_d       = count_q;
    charLatch_d   = charLatch_q;
    row_d         = row_q;
    col_d         = col_q;
    addrPending_d = addrPending_q;
    holdCnt_d     = holdCnt_q;
    lcdValid_d    = lcdValid_q;
    lcdAod_d      = lcdAod_q;
    lcdData_d     = lcdData_q;

    if (clearReq_i) begin
      state_d       = IDLE;
      wrPtr_d       = '0;
      rdPtr_d       = '0;
      count_d       = '0;
      row_d         = '0;
      col_d         = '0;
      addrPending_d = 1'b1;
      holdCnt_d     = '0;
      lcdValid_d    = 1'b0;
      lcdAod_d      = 1'b0;
      lcdData_d     = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      case (state_q)
        IDLE: begin
          lcdValid_d = 1'b0;
          lcdAod_d   = 1'b0;
          lcdData_d  = '0;
          if (pop) begin
            rdPtr_d     = rdPtr_q + AW'(1);
            charLatch_d = headChar;
            lcdValid_d  = 1'b1;
            // A newline moves the cursor at the pop, so its address item already
            // points at the start of the new line.
            if (headChar == NEWLINE) begin
              row_d     = nextRow(row_q);
              col_d     = '0;
              state_d   = ADDR;
              lcdData_d = addrCmd(nextRow(row_q), 4'd0);
            end else if (addrPending_q) begin
              state_d   = ADDR;
              lcdData_d = addrCmd(row_q, col_q);
            end else begin
              state_d   = DATA;
              lcdAod_d  = 1'b1;
              lcdData_d = headChar;
            end
          end
        end

        ADDR, DATA: begin
          if (!lcdBusLock_i) begin
            if (holdCnt_q == HOLD_MAX) begin
              holdCnt_d = '0;
              if (state_q == ADDR) begin
                addrPending_d = 1'b0;
                if (charLatch_q == NEWLINE) begin
                  state_d    = IDLE;
                  lcdValid_d = 1'b0;
                  lcdAod_d   = 1'b0;
                  lcdData_d  = '0;
                end else begin
                  state_d   = DATA;
                  lcdAod_d  = 1'b1;
                  lcdData_d = charLatch_q;
                end
              end else begin
                state_d    = IDLE;
                lcdValid_d = 1'b0;
                lcdAod_d   = 1'b0;
                lcdData_d  = '0;
                if (colPlus == 5'(COLS)) begin
                  col_d         = '0;
                  row_d         = nextRow(row_q);
                  addrPending_d = 1'b1;
                end else begin
                  col_d = colPlus[3:0];
                end
              end
            end else begin
              holdCnt_d = holdCnt_q + HW'(1);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Ready reflects the occupancy after this edge, and is withheld for one
    // cycle after a clear.
    charReady_d = (count_d < CW'(FIFO_DEPTH)) && !clearReq_i;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= charData_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      charReady_q   <= 1'b0;
      charLatch_q   <= '0;
      row_q         <= '0;
      col_q         <= '0;
      addrPending_q <= 1'b1;
      holdCnt_q     <= '0;
      lcdValid_q    <= 1'b0;
      lcdAod_q      <= 1'b0;
      lcdData_q     <= '0;
    end else begin
      state_q       <= state_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      charReady_q   <= charReady_d;
      charLatch_q   <= charLatch_d;
      row_q         <= row_d;
      col_q         <= col_d;
      addrPending_q <= addrPending_d;
      holdCnt_q     <= holdCnt_d;
      lcdValid_q    <= lcdValid_d;
      lcdAod_q      <= lcdAod_d;
      lcdData_q     <= lcdData_d;
    end
  end

  assign charReady_o     = charReady_q;
  assign lcdValid_o      = lcdValid_q;
  assign lcdAddrOrData_o = lcdAod_q;
  assign lcdDataOut_o    = lcdData_q;
  assign fifoCount_o     = count_q;
  assign cursorPos_o     = {row_q, col_q};

endmodule

// File: tb/tb_lcd_char_feeder.sv
// Scoreboard bench for lcd_char_feeder: a cursor model queues expected items,
// a forked monitor pops and compares each item the DUT presents.
module tb_lcd_char_feeder;

  localparam int HOLD  = 40;
  localparam int LOCK  = 25;
  localparam int DEPTH = 16;
  localparam int COLS  = 16;
  localparam int ROWS  = 2;
  localparam int LIMIT = 20 * (HOLD + 4);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       charValid = 1'b0;
  logic [7:0] charData = 8'h00;
  logic       charReady;
  logic       clearReq = 1'b0;
  logic       lcdBusLock = 1'b0;
  logic       lcdValid;
  logic       lcdAddrOrData;
  logic [7:0] lcdDataOut;
  logic [4:0] fifoCount;
  logic [7:0] cursorPos;

  int errors = 0;
  int checks = 0;

  logic [8:0] expQ [$];
  logic [3:0] modelRow = 4'd0;
  logic [3:0] modelCol = 4'd0;
  logic       modelPend = 1'b1;

  logic       monInItem = 1'b0;
  logic       monAbort = 1'b0;
  logic [8:0] monCur = '0;
  int         monCyc = 0;
  int         monUnl = 0;
  int         monLastDur = 0;
  int         monNlData = 0;

  lcd_char_feeder #(
    .FIFO_DEPTH (DEPTH),
    .COLS       (COLS),
    .ROWS       (ROWS),
    .LINE0_BASE (7'h00),
    .LINE1_BASE (7'h40),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .charValid_i    (charValid),
    .charData_i     (charData),
    .charReady_o    (charReady),
    .clearReq_i     (clearReq),
    .lcdBusLock_i   (lcdBusLock),
    .lcdValid_o     (lcdValid),
    .lcdAddrOrData_o(lcdAddrOrData),
    .lcdDataOut_o   (lcdDataOut),
    .fifoCount_o    (fifoCount),
    .cursorPos_o    (cursorPos)
  );

  always #5 clk = ~clk;

  initial begin
    #(50000 * 10);
    $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [8:0] addrItem(input logic [3:0] r, input logic [3:0] c);
    logic [6:0] base;
    base = (r == 4'd0) ? 7'h00 : 7'h40;
    return {1'b0, 1'b1, base + {3'b000, c}};
  endfunction

  task automatic resetModel();
    modelRow  = 4'd0;
    modelCol  = 4'd0;
    modelPend = 1'b1;
  endtask

  task automatic modelPush(input logic [7:0] c);
    if (c == 8'h0A) begin
      modelRow = (modelRow == 4'(ROWS - 1)) ? 4'd0 : modelRow + 4'd1;
      modelCol = 4'd0;
      expQ.push_back(addrItem(modelRow, modelCol));
      modelPend = 1'b0;
    end else begin
      if (modelPend) expQ.push_back(addrItem(modelRow, modelCol));
      modelPend = 1'b0;
      expQ.push_back({1'b1, c});
      if (int'(modelCol) + 1 == COLS) begin
        modelCol  = 4'd0;
        modelRow  = (modelRow == 4'(ROWS - 1)) ? 4'd0 : modelRow + 4'd1;
        modelPend = 1'b1;
      end else begin
        modelCol = modelCol + 4'd1;
      end
    end
  endtask

  task automatic monitor();
    logic [8:0] obs;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      obs = {lcdAddrOrData, lcdDataOut};
      if (monInItem && (lcdValid !== 1'b1 || obs !== monCur)) begin
        monLastDur = monCyc;
        if (monAbort) begin
          monAbort = 1'b0;
        end else begin
          checks++;
          if (monUnl != HOLD) begin
            errors++;
            $display("[TB] FAIL hold_length item=%h unlocked=%0d required=%0d", monCur, monUnl, HOLD);
          end
        end
        monInItem = 1'b0;
      end
      if (lcdValid === 1'b1 && !monInItem) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_item got=%h required=none", obs);
        end else begin
          exp = expQ.pop_front();
          if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL item_value got=%h required=%h", obs, exp);
          end
        end
        if (obs == 9'h10A) monNlData++;
        monCur    = obs;
        monInItem = 1'b1;
        monCyc    = 0;
        monUnl    = 0;
      end
      if (monInItem) begin
        monCyc++;
        if (!lcdBusLock) monUnl++;
      end
    end
  endtask

  task automatic pushChar(input logic [7:0] c);
    int n;
    n = 0;
    while (charReady !== 1'b1 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= LIMIT) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout char=%h ready=%b required=1", c, charReady);
    end else begin
      charValid = 1'b1;
      charData  = c;
      @(posedge clk); #1;
      charValid = 1'b0;
      modelPush(c);
    end
  endtask

  task automatic doClear();
    clearReq = 1'b1;
    @(posedge clk); #1;
    clearReq = 1'b0;
    resetModel();
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (!(expQ.size() == 0 && !monInItem && lcdValid === 1'b0 && fifoCount === 5'd0) && n < 4 * LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 4 * LIMIT) begin
      errors++;
      $display("[TB] FAIL %s_drain pending=%0d required=0", name, expQ.size());
    end
  endtask

  task automatic waitItem(input logic needData, input string name);
    int n;
    n = 0;
    while (!(lcdValid === 1'b1 && (!needData || lcdAddrOrData === 1'b1)) && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("[TB] FAIL %s_wait valid=%b required=1", name, lcdValid);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({charReady, lcdValid, lcdAddrOrData, lcdDataOut, fifoCount, cursorPos} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b%b%b %h %h %h required=all zero",
               charReady, lcdValid, lcdAddrOrData, lcdDataOut, fifoCount, cursorPos);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (charReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got=%b required=1", charReady);
    end
  endtask

  task automatic test_single_char();
    doClear();
    pushChar(8'h41);
    waitDrain("single");
    checks++;
    if (monLastDur != HOLD) begin
      errors++;
      $display("[TB] FAIL single_duration got=%0d required=%0d", monLastDur, HOLD);
    end
    checks++;
    if (cursorPos !== 8'h01) begin
      errors++;
      $display("[TB] FAIL single_cursor got=%h required=01", cursorPos);
    end
  endtask

  task automatic test_line_wrap();
    doClear();
    for (int i = 0; i < 17; i++) pushChar(8'h61 + 8'(i));
    waitDrain("line_wrap");
    checks++;
    if (cursorPos !== 8'h11) begin
      errors++;
      $display("[TB] FAIL line_wrap_cursor got=%h required=11", cursorPos);
    end
  endtask

  task automatic test_screen_wrap();
    doClear();
    for (int i = 0; i < 33; i++) pushChar(8'h30 + 8'(i));
    waitDrain("screen_wrap");
    checks++;
    if (cursorPos !== {modelRow, modelCol} || cursorPos !== 8'h01) begin
      errors++;
      $display("[TB] FAIL screen_wrap_cursor got=%h required=01", cursorPos);
    end
  endtask

  task automatic test_newline();
    int nl0;
    doClear();
    nl0 = monNlData;
    pushChar(8'h48);
    pushChar(8'h0A);
    pushChar(8'h49);
    waitDrain("newline");
    checks++;
    if (monNlData != nl0) begin
      errors++;
      $display("[TB] FAIL newline_as_data got=%0d required=0", monNlData - nl0);
    end
    checks++;
    if (cursorPos !== 8'h11) begin
      errors++;
      $display("[TB] FAIL newline_cursor got=%h required=11", cursorPos);
    end
  endtask

  task automatic test_bus_lock();
    int unstable;
    doClear();
    pushChar(8'h4C);
    waitItem(1'b1, "lock");
    repeat (10) begin @(posedge clk); #1; end
    lcdBusLock = 1'b1;
    unstable = 0;
    for (int i = 0; i < LOCK; i++) begin
      @(posedge clk); #1;
      if (lcdValid !== 1'b1 || lcdAddrOrData !== 1'b1 || lcdDataOut !== 8'h4C) unstable++;
    end
    lcdBusLock = 1'b0;
    waitDrain("lock");
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("[TB] FAIL lock_stable unstable_cycles=%0d required=0", unstable);
    end
    checks++;
    if (monLastDur != HOLD + LOCK) begin
      errors++;
      $display("[TB] FAIL lock_duration got=%0d required=%0d", monLastDur, HOLD + LOCK);
    end
  endtask

  task automatic test_overflow_clear();
    int accepted;
    int refused;
    doClear();
    lcdBusLock = 1'b1;
    pushChar(8'h5A);
    accepted = 0;
    refused  = 0;
    for (int i = 0; i < 20; i++) begin
      charValid = 1'b1;
      charData  = 8'h30 + 8'(i);
      if (charReady === 1'b1) accepted++;
      else refused++;
      @(posedge clk); #1;
    end
    charValid = 1'b0;
    checks++;
    if (accepted != DEPTH || refused != 4) begin
      errors++;
      $display("[TB] FAIL overflow_counts accepted=%0d refused=%0d required=16/4", accepted, refused);
    end
    checks++;
    if (fifoCount !== 5'd16 || charReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_full count=%0d ready=%b required=16/0", fifoCount, charReady);
    end
    monAbort = 1'b1;
    clearReq = 1'b1;
    charValid = 1'b1;
    charData  = 8'h55;
    @(posedge clk); #1;
    clearReq  = 1'b0;
    charValid = 1'b0;
    checks++;
    if (fifoCount !== 5'd0 || lcdValid !== 1'b0 || cursorPos !== 8'h00 || charReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_state count=%0d valid=%b cursor=%h ready=%b required=0/0/00/0",
               fifoCount, lcdValid, cursorPos, charReady);
    end
    @(negedge clk); #1;
    expQ.delete();
    resetModel();
    lcdBusLock = 1'b0;
    @(posedge clk); #1;

    pushChar(8'h52);
    waitItem(1'b0, "rst_hold");
    repeat (5) begin @(posedge clk); #1; end
    monAbort = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({charReady, lcdValid, lcdAddrOrData, lcdDataOut, fifoCount, cursorPos} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_hold ready=%b valid=%b aod=%b data=%h count=%h cursor=%h required=all zero",
               charReady, lcdValid, lcdAddrOrData, lcdDataOut, fifoCount, cursorPos);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
    resetModel();

    pushChar(8'h4B);
    waitDrain("after_reset");
    checks++;
    if (cursorPos !== 8'h01) begin
      errors++;
      $display("[TB] FAIL after_reset_cursor got=%h required=01", cursorPos);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_char();
    test_line_wrap();
    test_screen_wrap();
    test_newline();
    test_bus_lock();
    test_overflow_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
